// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter: accepts one byte per valid/ready handshake and
// serialises it LSB first with one start bit and one stop bit.
module uart_transmitter #(
    parameter int unsigned ClockFreq = 50_000_000,
    parameter int unsigned BaudRate  = 115_200
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [7:0] DataIn,
    input  logic       DataInValid,
    output logic       DataInReady,
    output logic       SOut
);

    localparam int unsigned BitPeriod  = ClockFreq / BaudRate;
    localparam int unsigned CountWidth = $clog2(BitPeriod) + 1;
    localparam logic [CountWidth-1:0] LastCount = CountWidth'(BitPeriod - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [CountWidth-1:0] r_count;
    logic [CountWidth-1:0] w_count_next;
    logic [2:0]            r_bit_idx;
    logic [2:0]            w_bit_idx_next;
    logic [7:0]            r_shift;
    logic [7:0]            w_shift_next;
    logic                  r_sout;
    logic                  w_sout_next;
    logic                  w_bit_done;

    assign w_bit_done  = (r_count == LastCount);
    assign DataInReady = (r_state == IDLE) && !Reset;
    assign SOut        = r_sout;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state   <= IDLE;
            r_count   <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_sout    <= 1'b1;
        end else begin
            r_state   <= w_state_next;
            r_count   <= w_count_next;
            r_bit_idx <= w_bit_idx_next;
            r_shift   <= w_shift_next;
            r_sout    <= w_sout_next;
        end
    end

    // The shift register is consumed from bit 0: each bit boundary drives
    // r_shift[0] onto the line and shifts the remaining bits down.
    always_comb begin
        w_state_next   = r_state;
        w_count_next   = r_count + 1'b1;
        w_bit_idx_next = r_bit_idx;
        w_shift_next   = r_shift;
        w_sout_next    = r_sout;
        case (r_state)
            IDLE: begin
                w_count_next   = '0;
                w_bit_idx_next = '0;
                w_sout_next    = 1'b1;
                if (DataInValid && DataInReady) begin
                    w_shift_next = DataIn;
                    w_sout_next  = 1'b0;
                    w_state_next = START;
                end
            end
            START: begin
                if (w_bit_done) begin
                    w_count_next = '0;
                    w_sout_next  = r_shift[0];
                    w_shift_next = {1'b0, r_shift[7:1]};
                    w_state_next = DATA;
                end
            end
            DATA: begin
                if (w_bit_done) begin
                    w_count_next = '0;
                    if (r_bit_idx == 3'd7) begin
                        w_bit_idx_next = '0;
                        w_sout_next    = 1'b1;
                        w_state_next   = STOP;
                    end else begin
                        w_bit_idx_next = r_bit_idx + 1'b1;
                        w_sout_next    = r_shift[0];
                        w_shift_next   = {1'b0, r_shift[7:1]};
                    end
                end
            end
            STOP: begin
                if (w_bit_done) begin
                    w_count_next = '0;
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_count_next = '0;
                w_sout_next  = 1'b1;
                w_state_next = IDLE;
            end
        endcase
    end

    // A bit period below two clocks cannot be timed by this counter scheme.
    always_ff @(posedge Clock) begin
        assert (BitPeriod >= 2)
        else $error("uart_transmitter: bit period %0d is below 2 clocks", BitPeriod);
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed and random-byte bench for uart_transmitter with T = 10 clocks,
// including a line-level receiver model for the random section.
module tb_uart_transmitter;

    localparam int unsigned ClockFreq = 1000;
    localparam int unsigned BaudRate  = 100;
    localparam int          T         = 10;

    logic       Clock = 1'b0;
    logic       Reset;
    logic [7:0] DataIn;
    logic       DataInValid;
    logic       DataInReady;
    logic       SOut;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    bit         rx_en    = 1'b0;
    int         rx_ferr  = 0;
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];

    always #5 Clock = ~Clock;

    uart_transmitter #(
        .ClockFreq(ClockFreq),
        .BaudRate (BaudRate)
    ) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .DataIn     (DataIn),
        .DataInValid(DataInValid),
        .DataInReady(DataInReady),
        .SOut       (SOut)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic frame_bit(input logic [7:0] b, input int c);
        if (c < T) return 1'b0;
        if (c < 9 * T) return b[c / T - 1];
        return 1'b1;
    endfunction

    task automatic do_handshake(input logic [7:0] b);
        int waited = 0;
        while (!DataInReady && waited < 300) begin
            @(negedge Clock);
            waited++;
        end
        if (!DataInReady) check("hs_timeout", 32'd0, 32'd1);
        DataIn      = b;
        DataInValid = 1'b1;
        @(posedge Clock);
        #1;
    endtask

    // Called just after handshake edge k; ends at the negedge following k+10T.
    task automatic check_frame(input logic [7:0] b, input int poke_cycle);
        for (int c = 0; c < 10 * T; c++) begin
            @(negedge Clock);
            check($sformatf("sout_%02h_c%0d", b, c), SOut, frame_bit(b, c));
            check($sformatf("rdy_%02h_c%0d", b, c), DataInReady, 1'b0);
            if (c == poke_cycle) begin
                DataIn      = 8'hFF;
                DataInValid = 1'b1;
            end else if (c == poke_cycle + 1) begin
                DataInValid = 1'b0;
            end
        end
        @(negedge Clock);
        check($sformatf("sout_end_%02h", b), SOut, 1'b1);
        check($sformatf("rdy_end_%02h", b), DataInReady, 1'b1);
    endtask

    initial begin : rx_model
        logic [7:0] d;
        forever begin
            @(negedge Clock);
            if (rx_en && SOut == 1'b0) begin
                repeat (T / 2) @(negedge Clock);
                if (SOut !== 1'b0) rx_ferr++;
                for (int i = 0; i < 8; i++) begin
                    repeat (T) @(negedge Clock);
                    d[i] = SOut;
                end
                repeat (T) @(negedge Clock);
                if (SOut !== 1'b1) rx_ferr++;
                rx_q.push_back(d);
            end
        end
    end

    initial begin
        int busy;
        logic [7:0] b;

        Reset       = 1'b1;
        DataIn      = 8'h00;
        DataInValid = 1'b0;

        repeat (3) begin
            @(negedge Clock);
            check("rst_sout", SOut, 1'b1);
            check("rst_rdy", DataInReady, 1'b0);
        end
        @(posedge Clock);
        #1 Reset = 1'b0;
        repeat (3) begin
            @(negedge Clock);
            check("post_rst_rdy", DataInReady, 1'b1);
            check("idle_sout", SOut, 1'b1);
        end

        // Single frame 0x55
        do_handshake(8'h55);
        DataInValid = 1'b0;
        check_frame(8'h55, -10);

        // Back-to-back with valid held: second start lands at k+101
        do_handshake(8'hA3);
        DataIn = 8'h0F;
        check_frame(8'hA3, -10);
        @(posedge Clock);
        #1 DataInValid = 1'b0;
        check_frame(8'h0F, -10);

        // Input changes mid-frame are ignored, no extra frame follows
        do_handshake(8'h81);
        DataInValid = 1'b0;
        check_frame(8'h81, 53);
        repeat (30) begin
            @(negedge Clock);
            check("no_extra_sout", SOut, 1'b1);
            check("no_extra_rdy", DataInReady, 1'b1);
        end
        DataIn = 8'h00;

        // Reset during data bit 3 of 0x3C; valid is held high throughout reset
        do_handshake(8'h3C);
        DataInValid = 1'b0;
        for (int c = 0; c < 45; c++) begin
            @(negedge Clock);
            check($sformatf("sout_3c_c%0d", c), SOut, frame_bit(8'h3C, c));
        end
        Reset       = 1'b1;
        DataIn      = 8'h00;
        DataInValid = 1'b1;
        repeat (3) begin
            @(negedge Clock);
            check("abort_sout", SOut, 1'b1);
            check("abort_rdy", DataInReady, 1'b0);
        end
        Reset = 1'b0;
        @(posedge Clock);
        #1 DataInValid = 1'b0;
        check_frame(8'h00, -10);

        // Random bytes through the receiver model
        rx_en = 1'b1;
        repeat (3) @(negedge Clock);
        for (int i = 0; i < 200; i++) begin
            b = 8'($urandom);
            exp_q.push_back(b);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 5)) @(negedge Clock);
            do_handshake(b);
            DataInValid = 1'b0;
            busy = 0;
            while (busy < 200) begin
                @(negedge Clock);
                if (DataInReady) break;
                busy++;
            end
            check($sformatf("busy_len_%0d", i), busy, 100);
        end
        repeat (5) @(negedge Clock);
        check("rx_count", rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
            check($sformatf("rx_byte_%0d", i), rx_q[i], exp_q[i]);
        check("rx_framing", rx_ferr, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_transmitter.md
UART_TRANSMITTER -- requirements
Module: uart_transmitter

Interface
REQ-001 The block SHALL have parameter ClockFreq, default 50_000_000, meaning the Clock frequency in Hz.
REQ-002 The block SHALL have parameter BaudRate, default 115_200, meaning the serial line rate in bits/s.
REQ-003 The block SHALL have port Clock  input  1  the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port DataIn  input  8  the byte to transmit, sampled only on handshake.
REQ-006 The block SHALL have port DataInValid  input  1  high when the producer offers DataIn.
REQ-007 The block SHALL have port DataInReady  output  1  high when the block can accept a byte.
REQ-008 The block SHALL have port SOut  output  1  the serial line, idle high, driven from a register.

Function
REQ-009 Bit period T SHALL be ClockFreq/BaudRate with integer truncation; the counter is ceil(log2(T))+1 bits wide.
REQ-010 The frame SHALL be 8N1: one start bit (0), eight data bits LSB first, and one stop bit (1), each T cycles long.
REQ-011 The FSM SHALL have the states IDLE, START, DATA and STOP.
REQ-012 DataInReady SHALL be high only in IDLE with Reset low, and SHALL be a combinational decode of state.
REQ-013 A handshake SHALL occur on a rising edge where DataInValid=1 and DataInReady=1; DataIn latches into the shift register and the state moves to START at that edge.
REQ-014 SOut SHALL go to 0 at the handshake edge k and SHALL hold each bit for exactly T cycles: start bit from k to k+T, data bit i from k+(1+i)T, stop bit from k+9T.
REQ-015 At edge k+10T the state SHALL return to IDLE, SOut SHALL stay 1, and DataInReady SHALL rise.
REQ-016 The earliest next handshake SHALL be edge k+10T+1, so the stop bit lasts T+1 cycles when transfers are back-to-back.
REQ-017 DataIn and DataInValid SHALL be ignored outside IDLE; changing DataIn mid-frame SHALL NOT alter the frame in flight.
REQ-018 In IDLE, SOut SHALL be 1 and the bit counter and cycle counter SHALL hold at 0.
REQ-019 A data-bit index counter (0..7) SHALL advance once per T cycles in DATA; DATA exits to STOP after index 7 completes.
REQ-020 T < 2 SHALL be flagged by a simulation-time assertion; behaviour for T < 2 is undefined.

Reset
REQ-021 While Reset=1 at an edge: state SHALL go to IDLE, SOut to 1, the counters to 0, and the shift register to 0x00.
REQ-022 DataInReady SHALL be 0 whenever Reset=1, and no handshake SHALL be taken while Reset=1.
REQ-023 Reset asserted mid-frame SHALL abort the frame: SOut=1 from the next edge, with no further line transitions.
REQ-024 The first handshake after Reset is released SHALL be possible on the first edge with Reset=0.

Verification
Bench parameters: ClockFreq=1000 and BaudRate=100, giving T=10.
REQ-025 Reset held for 3 cycles -> SOut=1 and DataInReady=0 throughout; DataInReady=1 in the cycle after Reset falls.
REQ-026 Send 0x55 -> SOut is 0,1,0,1,0,1,0,1,0,1 in 10-cycle slots; DataInReady=0 for exactly 100 cycles after the handshake.
REQ-027 Send 0xA3 then 0x0F with DataInValid held high -> data bits 1,1,0,0,0,1,0,1, stop bit of 11 cycles, second start bit at edge k+101, data bits 1,1,1,1,0,0,0,0.
REQ-028 Send 0x81, change DataIn to 0xFF and pulse DataInValid during bit 4 -> line still carries 0x81 and no extra frame follows.
REQ-029 Assert Reset during data bit 3 of 0x3C -> SOut=1 on the next edge and stays 1; then send 0x00 -> a clean frame of start, eight zeros and stop.
REQ-030 Random bytes (>=200), compared by a bench UART receiver model -> every byte matches, no framing errors, and DataInReady never rises mid-frame.
